seq_addsub_nbit: RTL and testbench
==================================

Name: seq_addsub_nbit

Overview:
- Parametrised multi-cycle add/subtract unit; successor to the fixed 4-bit ripple subtractor.
- Processes CHUNK bits per clock through a registered carry/borrow chain, over WIDTH/CHUNK cycles.
- Supports add and subtract, unsigned and signed interpretation, and full status flags.
- Start/done handshake; sits between the lab's operand registers/switch inputs and the display/ALU result path.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK (derived localparam, ≥1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  1  0 = subtract (a − b − cin), 1 = add (a + b + cin)
- signed_mode  input  1  1 = two's-complement flag interpretation
- a  input  WIDTH  minuend / augend
- b  input  WIDTH  subtrahend / addend
- cin  input  1  borrow-in (sub) or carry-in (add)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result/flags valid
- result  output  WIDTH  difference or sum
- cout  output  1  final borrow (sub) or carry (add)
- negative  output  1  result is negative
- zero  output  1  result == 0
- overflow  output  1  range overflow

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge):
  - State S_IDLE.
  - busy, done, result, cout, negative, zero and overflow all 0.
  - Reset mid-operation aborts the operation; no done is produced.
- S_IDLE:
  - start=1 at edge E0: latch a, b, op, signed_mode; chain register = cin; chunk index = 0; go to S_RUN.
  - busy=1 from E0.
  - a, b, op, signed_mode and cin may change after E0 without effect.
- S_RUN:
  - Each cycle, chunk i = bits [i*CHUNK +: CHUNK] is computed combinationally from the latched operands and the chain register.
  - At the next edge the slice is written into result and the chain register updates.
  - start is ignored while in S_RUN.
  - After the edge that writes chunk NCHUNK−1 (edge E0+NCHUNK), go to S_DONE.
- S_DONE (one cycle):
  - done=1, busy=0; result and all flags are valid.
  - start=1 in this cycle is accepted exactly as in S_IDLE (back-to-back).
  - Otherwise go to S_IDLE.
- Latency: done is high in the cycle after edge E0+NCHUNK. With NCHUNK=1 the latency is 1 cycle.
- Holding: result and flags hold their values through S_IDLE until the next accepted start.
  - The result register updates chunk by chunk during S_RUN; it is not guaranteed stable while busy=1.
  - Flags are written at E0+NCHUNK.
- Arithmetic:
  - Subtract: diff = a ^ b ^ bin; borrow = (~a & b) | (~(a ^ b) & bin).
  - Add: standard full-adder chain.
  - cout is the chain register after the final chunk.
- Flags:
  - zero = (result == 0).
  - Unsigned mode: overflow = cout. negative = cout for subtract, 0 for add.
  - Signed mode, add: overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]).
  - Signed mode, subtract: overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]).
  - Signed mode: negative = result[MSB] ^ overflow (true sign).
- Simultaneous events: rst_n=0 overrides start.

Decomposition:
- Package addsub_pkg:
  - typedef enum logic {OP_SUB=0, OP_ADD=1} op_e.
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e.
- One sub-module, addsub_chunk (parameter CHUNK):
  - Inputs: a, b, op, cin. Outputs: sum/diff, cout.
  - Purely combinational ripple chain, instantiated once.
  - The top level holds the FSM, chunk index, chain register, operand latches and flag logic.
- Top level checks WIDTH % CHUNK == 0 with an elaboration-time assertion.

Test Plan (WIDTH=8, CHUNK=4 unless noted):
1. Unsigned sub 0x35−0x12, cin=0 → result 0x23, cout=0, negative=0, zero=0; done high in the cycle after edge E0+2, busy high for 2 cycles.
2. Unsigned sub 0x12−0x35, cin=0 → 0xDD, cout=1, negative=1, overflow=1 (borrow crosses the chunk boundary). Also 0x10−0x00 with cin=1 → 0x0F, cout=0.
3. Signed sub 0x80−0x01 → 0x7F, overflow=1, negative=1. Signed sub 0x05−0x07 → 0xFE, overflow=0, negative=1.
4. Unsigned add 0xFF+0x01, cin=0 → 0x00, cout=1, zero=1. Signed add 0x7F+0x01 → 0x80, overflow=1, negative=0.
5. Handshake:
   - start pulsed during S_RUN is ignored (single done).
   - start held in the S_DONE cycle launches a second operation immediately; done pulses exactly once per accepted start.
6. Reset and corner configurations:
   - rst_n=0 in the first S_RUN cycle → next cycle all outputs 0 and state idle; a subsequent start completes correctly.
   - Repeat scenario 1 with CHUNK=8 (latency 1) and with WIDTH=16, CHUNK=4 for 0x0000−0x0001 → 0xFFFF, cout=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the sequential add/subtract unit.
package addsub_pkg;

    typedef enum logic {
        OP_SUB = 1'b0,
        OP_ADD = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Two's-complement range overflow from the operand and result sign bits.
    // Valid for both operations, with or without a carry/borrow in.
    function automatic logic signed_ovf(input logic is_add, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        logic ovf_v;
        if (is_add) begin
            ovf_v = (a_msb == b_msb) && (r_msb != a_msb);
        end else begin
            ovf_v = (a_msb != b_msb) && (r_msb != a_msb);
        end
        return ovf_v;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the add/subtract ripple chain (purely combinational).
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  op_e              i_op,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK:0] w_chain;

    // Ripple the carry (add) or borrow (subtract) through the slice bit by bit.
    always_comb begin
        w_chain    = '0;
        o_sum      = '0;
        w_chain[0] = i_cin;
        for (int i = 0; i < CHUNK; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_chain[i];
            if (i_op == OP_ADD) begin
                w_chain[i+1] = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & w_chain[i]);
            end else begin
                w_chain[i+1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_chain[i]);
            end
        end
        o_cout = w_chain[CHUNK];
    end

endmodule

// File: rtl/seq_addsub_nbit.sv
// Multi-cycle add/subtract: CHUNK bits per clock through a registered
// carry/borrow, with start/done handshake and full status flags.
module seq_addsub_nbit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             negative,
    output logic             zero,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
    localparam int MSB    = WIDTH - 1;

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_cfg
            $error("seq_addsub_nbit: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    op_e              r_op;
    logic             r_signed;
    logic             r_chain;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_neg;
    logic             r_zero;
    logic             r_ovf;

    int               w_base;
    logic             w_last;
    logic             w_accept;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_result_fin;
    logic             w_ovf_fin;
    logic             w_neg_fin;

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign negative = r_neg;
    assign zero     = r_zero;
    assign overflow = r_ovf;

    assign w_base = int'(r_idx) * CHUNK;
    assign w_last = (r_idx == LAST_IDX);

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .i_a    (r_a[w_base +: CHUNK]),
        .i_b    (r_b[w_base +: CHUNK]),
        .i_op   (r_op),
        .i_cin  (r_chain),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // A new request is taken when idle or in the done cycle (back-to-back).
    always_comb begin
        w_accept = 1'b0;
        if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
            w_accept = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Next-state logic for the idle/run/done sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
                else       w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DONE;
                else        w_state_nxt = S_RUN;
            end
            S_DONE: begin
                if (start) w_state_nxt = S_RUN;
                else       w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Final result (with the slice being written this cycle) and its flags.
    always_comb begin
        w_result_fin = r_result;
        w_result_fin[w_base +: CHUNK] = w_sum;
        if (r_signed) begin
            w_ovf_fin = signed_ovf(r_op == OP_ADD, r_a[MSB], r_b[MSB], w_result_fin[MSB]);
            w_neg_fin = w_result_fin[MSB] ^ w_ovf_fin;
        end else begin
            w_ovf_fin = w_cout;
            if (r_op == OP_SUB) w_neg_fin = w_cout;
            else                w_neg_fin = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latches, chunk walk, result/flag registers and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_SUB;
            r_signed <= 1'b0;
            r_chain  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_op     <= op_e'(op);
                r_signed <= signed_mode;
                r_chain  <= cin;
                r_idx    <= '0;
            end else if (r_state == S_RUN) begin
                r_result[w_base +: CHUNK] <= w_sum;
                r_chain <= w_cout;
                if (w_last) begin
                    r_cout <= w_cout;
                    r_zero <= (w_result_fin == '0);
                    r_neg  <= w_neg_fin;
                    r_ovf  <= w_ovf_fin;
                end else begin
                    r_idx <= r_idx + IDXW'(1);
                end
            end else begin
                r_chain <= r_chain;
            end
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_seq_addsub_nbit.sv
// Self-checking bench: three configurations (8/4, 8/8, 16/4), scoreboard of
// expected results pushed at start and popped on done, plus directed timing checks.
module tb_seq_addsub_nbit;
    import addsub_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic        co;
        logic        ng;
        logic        zr;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic        op_in, sm_in, cin_in;
    logic [15:0] a_in, b_in;

    logic        busy0, done0, co0, ng0, zr0, ov0;
    logic [7:0]  res0;
    logic        busy1, done1, co1, ng1, zr1, ov1;
    logic [7:0]  res1;
    logic        busy2, done2, co2, ng2, zr2, ov2;
    logic [15:0] res2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   dcnt0  = 0;

    always #5 clk = ~clk;

    seq_addsub_nbit #(.WIDTH(8), .CHUNK(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op_in), .signed_mode(sm_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in), .busy(busy0), .done(done0),
        .result(res0), .cout(co0), .negative(ng0), .zero(zr0), .overflow(ov0));

    seq_addsub_nbit #(.WIDTH(8), .CHUNK(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op_in), .signed_mode(sm_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in), .busy(busy1), .done(done1),
        .result(res1), .cout(co1), .negative(ng1), .zero(zr1), .overflow(ov1));

    seq_addsub_nbit #(.WIDTH(16), .CHUNK(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op(op_in), .signed_mode(sm_in),
        .a(a_in), .b(b_in), .cin(cin_in), .busy(busy2), .done(done2),
        .result(res2), .cout(co2), .negative(ng2), .zero(zr2), .overflow(ov2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input logic [15:0] r, input logic co,
                           input logic ng, input logic zr, input logic ov, input exp_t e);
        chk({tag, "_result"},   32'(r),  32'(e.res));
        chk({tag, "_cout"},     32'(co), 32'(e.co));
        chk({tag, "_negative"}, 32'(ng), 32'(e.ng));
        chk({tag, "_zero"},     32'(zr), 32'(e.zr));
        chk({tag, "_overflow"}, 32'(ov), 32'(e.ov));
    endtask

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input int w, input logic op, input logic sm,
                                   input logic [15:0] a, input logic [15:0] b, input logic ci);
        exp_t   e;
        longint mask, half, ua, ub, sa, sb, full, st;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= half) ? ua - (mask + 1) : ua;
        sb = (ub >= half) ? ub - (mask + 1) : ub;
        if (op) begin
            full = ua + ub + longint'(ci);
            st   = sa + sb + longint'(ci);
        end else begin
            full = ua - ub - longint'(ci);
            st   = sa - sb - longint'(ci);
        end
        e.res = 16'(full & mask);
        e.co  = op ? (full > mask) : (full < 0);
        e.zr  = ((full & mask) == 0);
        if (sm) begin
            e.ov = (st >= half) || (st < -half);
            e.ng = (st < 0);
        end else begin
            e.ov = e.co;
            e.ng = op ? 1'b0 : e.co;
        end
        return e;
    endfunction

    function automatic logic busy_of(input int id);
        return (id == 0) ? busy0 : (id == 1) ? busy1 : busy2;
    endfunction

    function automatic logic done_of(input int id);
        return (id == 0) ? done0 : (id == 1) ? done1 : done2;
    endfunction

    // Scoreboard: every done pulse pops and compares one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done0 === 1'b1) begin
            dcnt0++;
            chk("u0_exp_avail", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp_out("u0", 16'(res0), co0, ng0, zr0, ov0, e);
            end
        end
        if (done1 === 1'b1) begin
            chk("u1_exp_avail", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp_out("u1", 16'(res1), co1, ng1, zr1, ov1, e);
            end
        end
        if (done2 === 1'b1) begin
            chk("u2_exp_avail", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                cmp_out("u2", res2, co2, ng2, zr2, ov2, e);
            end
        end
    end

    task automatic push_exp(input int id, input logic op, input logic sm,
                            input logic [15:0] a, input logic [15:0] b, input logic ci);
        if (id == 0)      q0.push_back(model(8, op, sm, a, b, ci));
        else if (id == 1) q1.push_back(model(8, op, sm, a, b, ci));
        else              q2.push_back(model(16, op, sm, a, b, ci));
    endtask

    // Launch one operation (called just after a falling edge), scramble the
    // inputs after acceptance, check busy each cycle and the done latency.
    task automatic run(input int id, input logic op, input logic sm,
                       input logic [15:0] a, input logic [15:0] b, input logic ci);
        int   lat;
        int   k;
        logic seen;
        lat = (id == 0) ? 3 : (id == 1) ? 2 : 5;
        op_in = op; sm_in = sm; a_in = a; b_in = b; cin_in = ci;
        start_v[id] = 1'b1;
        push_exp(id, op, sm, a, b, ci);
        @(posedge clk);
        #1;
        start_v = 3'b000;
        op_in = ~op; sm_in = ~sm; a_in = ~a; b_in = ~b; cin_in = ~ci;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 12) begin
            @(negedge clk);
            k++;
            if (done_of(id) === 1'b1) seen = 1'b1;
            else chk($sformatf("u%0d_busy_k%0d", id, k), 32'(busy_of(id)), 32'd1);
        end
        chk($sformatf("u%0d_latency", id), 32'(k), 32'(lat));
        chk($sformatf("u%0d_busy_at_done", id), 32'(busy_of(id)), 32'd0);
        @(negedge clk);
        chk($sformatf("u%0d_done_one_cycle", id), 32'(done_of(id)), 32'd0);
    endtask

    initial begin
        int d;
        int k;
        rst_n = 1'b0; start_v = 3'b000; op_in = 1'b0; sm_in = 1'b0; cin_in = 1'b0;
        a_in = 16'h0000; b_in = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_result", 32'(res0), 32'd0);
        chk("rst_flags", 32'({co0, ng0, zr0, ov0}), 32'd0);
        chk("rst_u2_busy_done", 32'({busy2, done2}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases on the 8/4 configuration.
        run(0, OP_SUB, 1'b0, 16'h0035, 16'h0012, 1'b0);
        chk("t1_result", 32'(res0), 32'h23);
        chk("t1_flags", 32'({co0, ng0, zr0, ov0}), 32'h0);
        run(0, OP_SUB, 1'b0, 16'h0012, 16'h0035, 1'b0);
        chk("t2_result", 32'(res0), 32'hDD);
        chk("t2_flags", 32'({co0, ng0, zr0, ov0}), 32'hD);
        run(0, OP_SUB, 1'b0, 16'h0010, 16'h0000, 1'b1);
        chk("t2b_result", 32'(res0), 32'h0F);
        chk("t2b_cout", 32'(co0), 32'd0);
        run(0, OP_SUB, 1'b1, 16'h0080, 16'h0001, 1'b0);
        chk("t3a_result", 32'(res0), 32'h7F);
        chk("t3a_ovf_neg", 32'({ov0, ng0}), 32'h3);
        run(0, OP_SUB, 1'b1, 16'h0005, 16'h0007, 1'b0);
        chk("t3b_result", 32'(res0), 32'hFE);
        chk("t3b_ovf_neg", 32'({ov0, ng0}), 32'h1);
        run(0, OP_ADD, 1'b0, 16'h00FF, 16'h0001, 1'b0);
        chk("t4a_result", 32'(res0), 32'h00);
        chk("t4a_cout_zero", 32'({co0, zr0}), 32'h3);
        run(0, OP_ADD, 1'b1, 16'h007F, 16'h0001, 1'b0);
        chk("t4b_result", 32'(res0), 32'h80);
        chk("t4b_ovf_neg", 32'({ov0, ng0}), 32'h2);
        repeat (3) @(negedge clk);
        chk("hold_result", 32'(res0), 32'h80);
        chk("hold_flags", 32'({co0, ng0, zr0, ov0}), 32'h1);

        // start during the run phase must be ignored.
        d = dcnt0;
        op_in = OP_ADD; sm_in = 1'b0; a_in = 16'h0021; b_in = 16'h0013; cin_in = 1'b1;
        start_v[0] = 1'b1;
        push_exp(0, OP_ADD, 1'b0, 16'h0021, 16'h0013, 1'b1);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1; op_in = OP_SUB; a_in = 16'h0001; b_in = 16'h0077;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5a_single_done", 32'(dcnt0 - d), 32'd1);
        chk("t5a_idle", 32'(busy0), 32'd0);

        // Back-to-back: start held in the done cycle launches the next op.
        d = dcnt0;
        op_in = OP_SUB; sm_in = 1'b1; a_in = 16'h0040; b_in = 16'h0041; cin_in = 1'b0;
        start_v[0] = 1'b1;
        push_exp(0, OP_SUB, 1'b1, 16'h0040, 16'h0041, 1'b0);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        k = 0;
        while (done0 !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t5b_first_done", 32'(done0), 32'd1);
        op_in = OP_ADD; sm_in = 1'b0; a_in = 16'h00C8; b_in = 16'h0064; cin_in = 1'b1;
        start_v[0] = 1'b1;
        push_exp(0, OP_ADD, 1'b0, 16'h00C8, 16'h0064, 1'b1);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("t5b_busy_again", 32'({busy0, done0}), 32'h2);
        k = 0;
        while (done0 !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t5b_second_done", 32'(done0), 32'd1);
        repeat (4) @(negedge clk);
        chk("t5b_two_dones", 32'(dcnt0 - d), 32'd2);

        // Reset in the first run cycle aborts the operation.
        d = dcnt0;
        op_in = OP_SUB; sm_in = 1'b0; a_in = 16'h0035; b_in = 16'h0012; cin_in = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy_done", 32'({busy0, done0}), 32'd0);
        chk("t6_rst_result", 32'(res0), 32'd0);
        chk("t6_rst_flags", 32'({co0, ng0, zr0, ov0}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_done", 32'(dcnt0 - d), 32'd0);
        run(0, OP_SUB, 1'b0, 16'h0035, 16'h0012, 1'b0);
        chk("t6_after_result", 32'(res0), 32'h23);

        // Corner configurations.
        run(1, OP_SUB, 1'b0, 16'h0035, 16'h0012, 1'b0);
        chk("t6_c8_result", 32'(res1), 32'h23);
        run(2, OP_SUB, 1'b0, 16'h0035, 16'h0012, 1'b0);
        chk("t6_w16_result", 32'(res2), 32'h0023);
        run(2, OP_SUB, 1'b0, 16'h0000, 16'h0001, 1'b0);
        chk("t6_w16_ffff", 32'(res2), 32'hFFFF);
        chk("t6_w16_cout", 32'(co2), 32'd1);

        // A few random operations across all three configurations.
        for (int i = 0; i < 9; i++) begin
            run(i % 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on simulation time.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
